hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core: tracks in-flight destination registers through E/M/W, and drives the stall line and every forwarding-mux select (the 2-bit selects consumed by the 3-input 32-bit datapath muxes). Sits beside the D/E/M/W pipeline registers. It is the producer side of the mux select interface. It holds its own shadow copy of the per-stage register numbers and Tnew counters.

## Interface
- No parameters.
- `clk` in 1: core clock, posedge.
- `reset` in 1: synchronous, active-high.
- `d_rs`, `d_rt` in 5 each: source registers of the instruction in D.
- `d_tuse_rs`, `d_tuse_rt` in 2 each: cycles from D until the operand is needed. 0 = branch/jr, 1 = ALU, 2 = store data, 3 = not used.
- `d_wreg` in 5: destination register of the D instruction. 0 = no write.
- `d_tnew` in 2: cycles after entering E until the result exists. 0 = link (PC+8), 1 = ALU, 2 = load.
- `d_md`, `d_md_start`, `d_md_div` in 1 each: uses HI/LO, starts mult/div, is div.
- `stall` out 1: hold PC and the D register, insert a bubble into E.
- `fwd_d_rs`, `fwd_d_rt` out 2 each: 0 = GRF, 1 = E result, 2 = M result.
- `fwd_e_rs`, `fwd_e_rt` out 2 each: 0 = E pipeline value, 1 = M result, 2 = W result.
- `fwd_m_rt` out 1: 0 = M pipeline value, 1 = W result.
- `md_busy` out 1: mult/div unit occupied.

## Operation
- Shadow stage registers:
  - E holds {rs, rt, wreg, tnew, md_start, md_div}.
  - M holds {rt, wreg, tnew}.
  - W holds {wreg}.
- Advance on every clock edge:
  - M.tnew = E.tnew − 1, saturating at 0.
  - W carries no tnew; its result is always ready.
  - When `stall`=1, E loads a bubble (all fields 0). Otherwise E loads the D inputs.
- Stall on rs when `d_rs`≠0 and either:
  - E.wreg==`d_rs` and E.tnew > `d_tuse_rs`, or
  - M.wreg==`d_rs` and M.tnew > `d_tuse_rs`.
- The same rule applies to rt. `stall` = rs_stall | rt_stall | md_stall.
- Forwarding:
  - Match requires reg≠0 and the source stage's tnew==0.
  - The nearest stage wins.
  - D-stage selects: E, then M. E-stage selects: M, then W. `fwd_m_rt`: W.
  - A match with tnew>0 never forwards; stall covers that case.
- Register 0 never stalls or forwards.
- A stall and a D-stage forward can be asserted together; the forward value is simply unused.

## Timing
- All outputs are combinational from the shadow state plus the D inputs. There is no output latency.
- State updates on the posedge of `clk`.
- Reset value of every shadow field is 0. After reset: `stall`=0, every `fwd_*`=0, `md_busy`=0.
- A `reset` asserted mid-stall clears the stage registers on that same edge. Any pending mult/div count is discarded.
- A load followed directly by a dependent ALU op gives exactly 1 stall cycle.
- A load followed directly by a dependent beq gives 2 stall cycles.

## Configuration
- Macro: `HAZARD_CTRL_MULTDIV_EN`.
- Defined:
  - Includes the `md_busy_ctr` instance.
  - When E.md_start=1, the counter loads 5 (mult) or 10 (div) on the next edge. It then decrements each cycle down to 0.
  - `md_busy` = (counter≠0) | E.md_start.
  - md_stall = `d_md` & `md_busy`.
  - A new start while busy cannot occur, because the D instruction is stalled.
- Undefined:
  - The `d_md*` ports remain and are ignored.
  - `md_busy`=0 and md_stall=0.

## Structure
- Shared package `hazard_pkg` holds:
  - FWD_* select encodings.
  - TUSE_NONE=3.
  - TNEW_* codes.
  - MD_MULT_CYC=5 and MD_DIV_CYC=10.
- One sub-module, `md_busy_ctr`: a 4-bit down-counter with load and busy output. It is instantiated only under the macro.

## Test plan
- ALU writes $8, next instruction is an ALU op reading $8:
  - The reader sees `stall`=0 and `fwd_e_rs`=1 in its E cycle.
  - One instruction later, the same reader position sees `fwd_e_rs`=2.
- lw $9, then add reading $9: `stall`=1 for exactly 1 cycle, then `fwd_e_rs`=2 in the next cycle.
- lw $9, then beq on $9: `stall`=1 for 2 cycles, then `fwd_d_rs`=0 (read from GRF with write-through).
- jal writes $31, then jr $31 immediately: `stall`=0 and `fwd_d_rs`=1 (E result, tnew=0).
- Write to $0 followed by readers of $0: `stall`=0 and all selects 0.
- With the macro defined, div then mfhi:
  - `md_busy` is high for 11 cycles from div entering E.
  - mfhi is stalled until `md_busy` falls.
  - A `reset` pulse in the middle of this clears `md_busy` on the next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings, shadow-stage records and hazard helper functions
// for the five-stage pipeline hazard controller.
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] FWD_D_GRF  = 2'd0;
  localparam logic [1:0] FWD_D_E    = 2'd1;
  localparam logic [1:0] FWD_D_M    = 2'd2;
  localparam logic [1:0] FWD_E_PIPE = 2'd0;
  localparam logic [1:0] FWD_E_M    = 2'd1;
  localparam logic [1:0] FWD_E_W    = 2'd2;
  localparam logic       FWD_M_PIPE = 1'b0;
  localparam logic       FWD_M_W    = 1'b1;

  localparam logic [1:0] TUSE_NONE  = 2'd3;

  localparam logic [1:0] TNEW_READY = 2'd0;
  localparam logic [1:0] TNEW_LINK  = 2'd0;
  localparam logic [1:0] TNEW_ALU   = 2'd1;
  localparam logic [1:0] TNEW_LOAD  = 2'd2;

  localparam logic [3:0] MD_MULT_CYC = 4'd5;
  localparam logic [3:0] MD_DIV_CYC  = 4'd10;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] wreg;
    logic [1:0] tnew;
  } m_stage_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == TNEW_READY) ? TNEW_READY : t - 2'd1;
  endfunction

  // A producer still computing (tnew) later than the reader's need (tuse) forces a stall.
  function automatic logic raw_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input e_stage_t e, input m_stage_t m);
    return (src != 5'd0) &&
           (((e.wreg == src) && (e.tnew > tuse)) ||
            ((m.wreg == src) && (m.tnew > tuse)));
  endfunction

  function automatic logic [1:0] fwd_d_sel(input logic [4:0] src, input e_stage_t e,
                                           input m_stage_t m);
    if (src == 5'd0) return FWD_D_GRF;
    if ((e.wreg == src) && (e.tnew == TNEW_READY)) return FWD_D_E;
    if ((m.wreg == src) && (m.tnew == TNEW_READY)) return FWD_D_M;
    return FWD_D_GRF;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [4:0] src, input m_stage_t m,
                                           input logic [4:0] w_wreg);
    if (src == 5'd0) return FWD_E_PIPE;
    if ((m.wreg == src) && (m.tnew == TNEW_READY)) return FWD_E_M;
    if (w_wreg == src) return FWD_E_W;
    return FWD_E_PIPE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D-stage operand descriptors in, stall / forward selects out.
`default_nettype none

interface hazard_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_wreg;
  logic [1:0] d_tnew;
  logic       d_md;
  logic       d_md_start;
  logic       d_md_div;
  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       fwd_m_rt;
  logic       md_busy;

  // master: pipeline datapath; slave: hazard controller
  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew, d_md, d_md_start, d_md_div,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew, d_md, d_md_start, d_md_div,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// md_busy_ctr: 4-bit load-and-decrement occupancy counter for the mult/div unit.
`default_nettype none

module md_busy_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       busy_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= 4'd0;
    else
      cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != 4'd0);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding-select generation from shadow E/M/W state.
// Mult/div occupancy tracking is built only with HAZARD_CTRL_MULTDIV_EN defined.
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  e_stage_t   e_q, e_d;
  m_stage_t   m_q, m_d;
  logic [4:0] w_wreg_q, w_wreg_d;

  logic rs_stall, rt_stall, md_stall, stall;
  logic md_busy;

  assign rs_stall = raw_stall(hz.d_rs, hz.d_tuse_rs, e_q, m_q);
  assign rt_stall = raw_stall(hz.d_rt, hz.d_tuse_rt, e_q, m_q);
  assign stall    = rs_stall | rt_stall | md_stall;

  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs       = hz.d_rs;
      e_d.rt       = hz.d_rt;
      e_d.wreg     = hz.d_wreg;
      e_d.tnew     = hz.d_tnew;
      e_d.md_start = hz.d_md_start;
      e_d.md_div   = hz.d_md_div;
    end
    m_d.rt   = e_q.rt;
    m_d.wreg = e_q.wreg;
    m_d.tnew = tnew_dec(e_q.tnew);
    w_wreg_d = m_q.wreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      m_q      <= '0;
      w_wreg_q <= 5'd0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_wreg_q <= w_wreg_d;
    end
  end

`ifdef HAZARD_CTRL_MULTDIV_EN
  logic md_ctr_busy;

  md_busy_ctr u_md_busy_ctr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (e_q.md_start),
    .load_val_i (e_q.md_div ? MD_DIV_CYC : MD_MULT_CYC),
    .busy_o     (md_ctr_busy)
  );

  // The starting op itself occupies the unit during its E cycle.
  assign md_busy  = md_ctr_busy | e_q.md_start;
  assign md_stall = hz.d_md & md_busy;
`else
  logic md_unused;

  assign md_unused = ^{hz.d_md, e_q.md_start, e_q.md_div};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  assign hz.stall    = stall;
  assign hz.md_busy  = md_busy;
  assign hz.fwd_d_rs = fwd_d_sel(hz.d_rs, e_q, m_q);
  assign hz.fwd_d_rt = fwd_d_sel(hz.d_rt, e_q, m_q);
  assign hz.fwd_e_rs = fwd_e_sel(e_q.rs, m_q, w_wreg_q);
  assign hz.fwd_e_rt = fwd_e_sel(e_q.rt, m_q, w_wreg_q);
  assign hz.fwd_m_rt = ((m_q.rt != 5'd0) && (w_wreg_q == m_q.rt)) ? FWD_M_W : FWD_M_PIPE;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl with hand-computed expectations.
`default_nettype none

module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  hazard_ctrl_if hz();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
                       input logic [4:0] wreg, input logic [1:0] tnew,
                       input logic md, input logic md_start, input logic md_div);
    hz.d_rs       = rs;
    hz.d_rt       = rt;
    hz.d_tuse_rs  = tuse_rs;
    hz.d_tuse_rt  = tuse_rt;
    hz.d_wreg     = wreg;
    hz.d_tnew     = tnew;
    hz.d_md       = md;
    hz.d_md_start = md_start;
    hz.d_md_div   = md_div;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, TNEW_LINK, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (4) step();
  endtask

`ifdef HAZARD_CTRL_MULTDIV_EN
  task automatic md_run(input logic is_div, input int exp_cyc, input string tag);
    int busy_cyc;
    int stall_cyc;
    busy_cyc  = 0;
    stall_cyc = 0;
    drive(5'd4, 5'd5, TNEW_ALU, TNEW_ALU, 5'd0, TNEW_ALU, 1'b1, 1'b1, is_div);
    #3;
    chk({tag, "_pre_busy"}, hz.md_busy, 0);
    step();
    drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd12, TNEW_ALU, 1'b1, 1'b0, 1'b0);
    #3;
    while (hz.md_busy && busy_cyc < 30) begin
      busy_cyc++;
      if (hz.stall) stall_cyc++;
      @(posedge clk);
      #3;
    end
    chk({tag, "_busy_cycles"}, busy_cyc, exp_cyc);
    chk({tag, "_mfhi_stall_cycles"}, stall_cyc, exp_cyc);
    chk({tag, "_mfhi_released"}, hz.stall, 0);
    #1;
    flush();
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    nop();
    step();
    step();
    reset = 1'b0;
    #3;
    chk("rst_stall", hz.stall, 0);
    chk("rst_fwd_d_rs", hz.fwd_d_rs, 0);
    chk("rst_fwd_d_rt", hz.fwd_d_rt, 0);
    chk("rst_fwd_e_rs", hz.fwd_e_rs, 0);
    chk("rst_fwd_e_rt", hz.fwd_e_rt, 0);
    chk("rst_fwd_m_rt", hz.fwd_m_rt, 0);
    chk("rst_md_busy", hz.md_busy, 0);
    #1;

    // ALU $8, ALU $8, reader1 (rs=$8), reader2 (rs=$8)
    drive(5'd1, 5'd2, TNEW_ALU, TNEW_ALU, 5'd8, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd2, 5'd3, TNEW_ALU, TNEW_ALU, 5'd8, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd8, 5'd0, TNEW_ALU, TUSE_NONE, 5'd10, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    #3;
    chk("alu_r1_stall", hz.stall, 0);
    chk("alu_r1_fwd_d_rs", hz.fwd_d_rs, 2);
    #1;
    step();
    drive(5'd8, 5'd0, TNEW_ALU, TUSE_NONE, 5'd11, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    #3;
    chk("alu_r1_fwd_e_rs_nearest", hz.fwd_e_rs, 1);
    chk("alu_r2_fwd_d_rs", hz.fwd_d_rs, 2);
    chk("alu_r2_stall", hz.stall, 0);
    #1;
    step();
    nop();
    #3;
    chk("alu_r2_fwd_e_rs_w", hz.fwd_e_rs, 2);
    #1;
    flush();

    // lw $9 then dependent add on rs
    drive(5'd1, 5'd0, TNEW_ALU, TUSE_NONE, 5'd9, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
    #3;
    chk("lw_add_pre_stall", hz.stall, 0);
    #1;
    step();
    drive(5'd9, 5'd2, TNEW_ALU, TNEW_ALU, 5'd12, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    #3;
    chk("lw_add_stall1", hz.stall, 1);
    #1;
    step();
    #3;
    chk("lw_add_stall2", hz.stall, 0);
    chk("lw_add_fwd_d_rs", hz.fwd_d_rs, 0);
    #1;
    step();
    nop();
    #3;
    chk("lw_add_fwd_e_rs", hz.fwd_e_rs, 2);
    #1;
    flush();

    // lw $9 then beq $5,$9 (dependency on rt)
    drive(5'd1, 5'd0, TNEW_ALU, TUSE_NONE, 5'd9, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd5, 5'd9, 2'd0, 2'd0, 5'd0, TNEW_LINK, 1'b0, 1'b0, 1'b0);
    #3;
    chk("lw_beq_stall1", hz.stall, 1);
    #1;
    step();
    #3;
    chk("lw_beq_stall2", hz.stall, 1);
    chk("lw_beq_fwd_d_rt_busy", hz.fwd_d_rt, 0);
    #1;
    step();
    #3;
    chk("lw_beq_stall3", hz.stall, 0);
    chk("lw_beq_fwd_d_rt_grf", hz.fwd_d_rt, 0);
    #1;
    flush();

    // reset during a load-use stall clears the shadow stages
    drive(5'd1, 5'd0, TNEW_ALU, TUSE_NONE, 5'd9, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd9, 5'd0, 2'd0, TUSE_NONE, 5'd0, TNEW_LINK, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rstmid_stall_before", hz.stall, 1);
    #1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #3;
    chk("rstmid_stall_after", hz.stall, 0);
    #1;
    flush();

    // jal $31 then jr $31, then reader of $31 on rt
    drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd31, TNEW_LINK, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd31, 5'd0, 2'd0, TUSE_NONE, 5'd0, TNEW_LINK, 1'b0, 1'b0, 1'b0);
    #3;
    chk("jal_jr_stall", hz.stall, 0);
    chk("jal_jr_fwd_d_rs", hz.fwd_d_rs, 1);
    #1;
    step();
    drive(5'd0, 5'd31, TUSE_NONE, TNEW_ALU, 5'd13, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    #3;
    chk("jal_rd_fwd_d_rt", hz.fwd_d_rt, 2);
    #1;
    flush();

    // $8 producer then sw with rt=$8: E-stage then M-stage forwarding of store data
    drive(5'd1, 5'd2, TNEW_ALU, TNEW_ALU, 5'd8, TNEW_ALU, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd3, 5'd8, TNEW_ALU, TNEW_LOAD, 5'd0, TNEW_LINK, 1'b0, 1'b0, 1'b0);
    #3;
    chk("sw_stall", hz.stall, 0);
    #1;
    step();
    nop();
    #3;
    chk("sw_fwd_e_rt", hz.fwd_e_rt, 1);
    #1;
    step();
    #3;
    chk("sw_fwd_m_rt", hz.fwd_m_rt, 1);
    #1;
    flush();

    // load into $0, then readers of $0
    drive(5'd1, 5'd0, TNEW_ALU, TUSE_NONE, 5'd0, TNEW_LOAD, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, TNEW_LINK, 1'b0, 1'b0, 1'b0);
    #3;
    chk("r0_stall", hz.stall, 0);
    chk("r0_fwd_d_rs", hz.fwd_d_rs, 0);
    chk("r0_fwd_d_rt", hz.fwd_d_rt, 0);
    #1;
    step();
    #3;
    chk("r0_stall2", hz.stall, 0);
    chk("r0_fwd_e_rs", hz.fwd_e_rs, 0);
    chk("r0_fwd_e_rt", hz.fwd_e_rt, 0);
    chk("r0_fwd_m_rt", hz.fwd_m_rt, 0);
    #1;
    flush();

`ifdef HAZARD_CTRL_MULTDIV_EN
    md_run(1'b1, 11, "div");
    md_run(1'b0, 6, "mult");

    drive(5'd4, 5'd5, TNEW_ALU, TNEW_ALU, 5'd0, TNEW_ALU, 1'b1, 1'b1, 1'b1);
    step();
    drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd12, TNEW_ALU, 1'b1, 1'b0, 1'b0);
    step();
    step();
    #3;
    chk("md_rst_busy_before", hz.md_busy, 1);
    #1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #3;
    chk("md_rst_busy_after", hz.md_busy, 0);
    chk("md_rst_stall_after", hz.stall, 0);
    #1;
    flush();
`else
    drive(5'd4, 5'd5, TNEW_ALU, TNEW_ALU, 5'd0, TNEW_ALU, 1'b1, 1'b1, 1'b1);
    step();
    drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd12, TNEW_ALU, 1'b1, 1'b0, 1'b0);
    #3;
    chk("nomd_busy", hz.md_busy, 0);
    chk("nomd_stall", hz.stall, 0);
    #1;
    flush();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
